// File: rtl/s_addsub_serial_pkg.sv
// Shared types and constants for the serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s_addsub_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/s_full_adder_bit.sv
// Combinational 1-bit full adder used by the serial datapath.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module s_full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/s_addsub_serial.sv
// Bit-serial N-bit add/subtract: loads A then B LSB-first, streams result, presents it in parallel.
// Latency: start to done pulse is 3N+1 cycles; next start may be accepted in the done cycle.
// Backpressure: none; start outside IDLE is ignored, s_in is only sampled during operand loading.
module s_addsub_serial
  import s_addsub_serial_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         mode,
  input  logic         s_in,
  output logic         s_out,
  output logic         s_valid,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           carry;
  logic           mode_q;
  logic           last;
  logic           b_eff;
  logic           fa_s;
  logic           fa_c;

  assign last = (cnt == CW'(N - 1));

  // Subtraction is A + ~B + 1: the +1 comes from carry being preset to 1 at start.
  assign b_eff = (mode_q == MODE_SUB) ? ~b[0] : b[0];

  s_full_adder_bit u_fa (
    .a    (a[0]),
    .b    (b_eff),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Controller FSM, operand shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      carry     <= 1'b0;
      mode_q    <= MODE_ADD;
      s_out     <= 1'b0;
      s_valid   <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      s_out   <= 1'b0;
      s_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high through the done cycle and drops on the following edge
          // unless a new operation is accepted on that same edge.
          busy <= start;
          if (start) begin
            mode_q <= mode;
            carry  <= mode;
            cnt    <= '0;
            state  <= LOAD_A;
          end
        end
        LOAD_A: begin
          a   <= {s_in, a[N-1:1]};
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          b   <= {s_in, b[N-1:1]};
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          // Result bits shift into the top of a as operand bits leave the bottom.
          a       <= {fa_s, a[N-1:1]};
          b       <= {1'b0, b[N-1:1]};
          carry   <= fa_c;
          s_out   <= fa_s;
          s_valid <= 1'b1;
          cnt     <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          sum       <= a;
          carry_out <= carry;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_addsub_serial.sv
// Directed self-checking bench for s_addsub_serial with N=4.
// Latency: checks done arrives exactly 3N+1 edges after the start-sampling edge.
// Backpressure: exercises ignored start while busy and clear mid-operation.
module tb_s_addsub_serial;

  localparam int N = 4;

  logic         clk;
  logic         clear;
  logic         start;
  logic         mode;
  logic         s_in;
  logic         s_out;
  logic         s_valid;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  s_addsub_serial #(.N(N)) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .mode      (mode),
    .s_in      (s_in),
    .s_out     (s_out),
    .s_valid   (s_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full operation; hold keeps start high so the next call begins in the done cycle.
  task automatic run_op(input string tag, input logic m, input logic [N-1:0] av,
                        input logic [N-1:0] bv, input logic [N-1:0] exp_sum,
                        input logic exp_c, input logic hold);
    int            edges;
    int            nval;
    logic          got_done;
    logic [N-1:0]  stream;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_done_low"}, done, 0);
    if (!hold) start = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      s_in = (i < N) ? av[i] : bv[i - N];
      @(posedge clk);
    end
    edges    = 2 * N;
    nval     = 0;
    got_done = 1'b0;
    stream   = '0;
    while (!got_done && edges < 3 * N + 6) begin
      @(posedge clk);
      #1;
      edges++;
      if (s_valid) begin
        if (nval < N) stream[nval] = s_out;
        nval++;
      end
      if (done) got_done = 1'b1;
    end
    chk({tag, "_latency"}, edges, 3 * N + 1);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_carry"}, carry_out, exp_c);
    chk({tag, "_stream"}, stream, exp_sum);
    chk({tag, "_nvalid"}, nval, N);
    chk({tag, "_busy_done"}, busy, 1);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_sum_hold"}, sum, exp_sum);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    clear = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    s_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_out", s_out, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    clear = 1'b0;

    // 10 + 3 = 13
    run_op("add", 1'b0, 4'b1010, 4'b0011, 4'b1101, 1'b0, 1'b0);
    // 15 + 1 wraps to 0 with carry
    run_op("add_wrap", 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
    // 10 - 3 = 7, no borrow
    run_op("sub", 1'b1, 4'b1010, 4'b0011, 4'b0111, 1'b1, 1'b0);
    // 3 - 10 = -7 -> 9, borrow
    run_op("sub_borrow", 1'b1, 4'b0011, 4'b1010, 4'b1001, 1'b0, 1'b0);
    // difference + subtrahend restores minuend: 7 + 3 = 10
    run_op("roundtrip", 1'b0, 4'b0111, 4'b0011, 4'b1010, 1'b0, 1'b0);

    // clear during LOAD_B
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      s_in = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_s_valid", s_valid, 0);
    chk("clr_sum", sum, 0);
    chk("clr_carry", carry_out, 0);
    chk("clr_done", done, 0);
    @(negedge clk);
    clear = 1'b0;
    ndone = 0;
    for (int i = 0; i < 3 * N + 3; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("clr_no_done", ndone, 0);
    chk("clr_idle", busy, 0);

    // clear and start together: start dropped
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_start_busy", busy, 0);
    clear = 1'b0;
    start = 1'b0;

    run_op("fresh", 1'b0, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0);

    // start held high: one done, second op issued in the first IDLE cycle
    run_op("hold1", 1'b0, 4'b0101, 4'b0010, 4'b0111, 1'b0, 1'b1);
    run_op("hold2", 1'b1, 4'b0100, 4'b0110, 4'b1110, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
